// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: N_REQ single-entry write slots funnelled onto one register-bank write port.
// Define REG_WRITE_ARBITER_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module reg_write_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   i_w_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_w_data,
  input  logic [N_REQ-1:0]              i_w_en,
  input  logic                          i_clear_overflow,
  output logic [ADDR_WIDTH-1:0]         o_w_addr,
  output logic [DATA_WIDTH-1:0]         o_w_data,
  output logic                          o_w_en,
  output logic [N_REQ-1:0]              o_pending,
  output logic [N_REQ-1:0]              o_overflow
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [ADDR_WIDTH-1:0] slot_addr [N_REQ];
  logic [DATA_WIDTH-1:0] slot_data [N_REQ];
  logic [N_REQ-1:0]      pend;
  logic                  gnt_vld_c;
  logic [IDX_W-1:0]      gnt_idx_c;
  logic [N_REQ-1:0]      gnt_oh_c;
  logic [N_REQ-1:0]      drop_c;

`ifdef REG_WRITE_ARBITER_FIXED_PRIO_EN
  // Lowest pending index wins; scanning downward leaves the lowest one assigned last.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (pend[IDX_W'(i)]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand_c;

  // Round-robin: first pending slot at or after last grant + 1, wrapping.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    cand_c    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_c = IDX_W'((32'(rr_ptr) + i + 32'd1) % N_REQ);
      if (!gnt_vld_c && pend[cand_c]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = cand_c;
      end
    end
  end

  // Pointer holds the last granted index; reset value makes requester 0 first.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      rr_ptr <= IDX_W'(N_REQ - 1);
    end else if (gnt_vld_c) begin
      rr_ptr <= gnt_idx_c;
    end
  end
`endif

  assign gnt_oh_c  = gnt_vld_c ? (N_REQ'(1) << gnt_idx_c) : '0;
  assign drop_c    = i_w_en & pend & ~gnt_oh_c;
  assign o_pending = pend;

  // Per-requester holding slot; a strobe on the granted cycle reloads the freed slot.
  for (genvar k = 0; k < N_REQ; k++) begin : g_slot
    always_ff @(posedge clk) begin
      if (i_reset) begin
        pend[k]      <= 1'b0;
        slot_addr[k] <= '0;
        slot_data[k] <= '0;
      end else if (i_w_en[k] && (!pend[k] || gnt_oh_c[k])) begin
        pend[k]      <= 1'b1;
        slot_addr[k] <= i_w_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        slot_data[k] <= i_w_data[k*DATA_WIDTH +: DATA_WIDTH];
      end else if (gnt_oh_c[k]) begin
        pend[k]      <= 1'b0;
      end
    end
  end

  // Register-bank port: address/data hold their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_w_en   <= 1'b0;
      o_w_addr <= '0;
      o_w_data <= '0;
    end else begin
      o_w_en <= gnt_vld_c;
      if (gnt_vld_c) begin
        o_w_addr <= slot_addr[gnt_idx_c];
        o_w_data <= slot_data[gnt_idx_c];
      end
    end
  end

  // Sticky drop flags; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_overflow <= '0;
    end else begin
      o_overflow <= (o_overflow & ~{N_REQ{i_clear_overflow}}) | drop_c;
    end
  end

endmodule
